// File: rtl/imm_ext_pipe.sv
// Pipelined immediate generator: zero/sign/shifted extension plus a PREFIX
// instruction that supplies upper bits, with a one-deep valid/ready output register.
module imm_ext_pipe #(
  parameter int DATA_W  = 32,
  parameter int IMM_A_W = 16,
  parameter int IMM_B_W = 24,
  parameter int PFX_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         mode,
  input  logic [IMM_A_W-1:0] imm_a,
  input  logic [IMM_B_W-1:0] imm_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  imm_out,
  output logic               pfx_used,
  output logic               err
);

  localparam int AX = DATA_W - IMM_A_W;
  localparam int BX = DATA_W - IMM_B_W;

  localparam logic [2:0] M_ZA  = 3'd0;
  localparam logic [2:0] M_SA  = 3'd1;
  localparam logic [2:0] M_ZB  = 3'd2;
  localparam logic [2:0] M_SB  = 3'd3;
  localparam logic [2:0] M_UP  = 3'd4;
  localparam logic [2:0] M_BR  = 3'd5;
  localparam logic [2:0] M_PFX = 3'd6;
  localparam logic [2:0] M_RSV = 3'd7;

  typedef enum logic {S_IDLE, S_PFX} pfx_st_t;

  pfx_st_t            r_state, w_state_nxt;
  logic [PFX_W-1:0]   r_pfx;
  logic               r_out_valid;
  logic [DATA_W-1:0]  r_imm;
  logic               r_pfx_used;
  logic               r_err;

  logic               w_accept, w_is_pfx, w_use_pfx, w_viol;
  logic [DATA_W-1:0]  w_za, w_sa, w_zb, w_sb, w_up, w_br, w_ext, w_res;

  assign in_ready  = !flush && (!r_out_valid || out_ready);
  assign w_accept  = in_valid && in_ready;
  assign w_is_pfx  = (mode == M_PFX);
  assign w_use_pfx = (r_state == S_PFX) && (mode == M_ZA || mode == M_SA);
  // A pending prefix may only be consumed by mode 0/1; anything else discards it.
  assign w_viol    = (mode == M_RSV) || ((r_state == S_PFX) && !w_use_pfx);

  assign w_za = {{AX{1'b0}}, imm_a};
  assign w_sa = {{AX{imm_a[IMM_A_W-1]}}, imm_a};
  assign w_zb = {{BX{1'b0}}, imm_b};
  assign w_sb = {{BX{imm_b[IMM_B_W-1]}}, imm_b};
  assign w_up = {imm_a, {AX{1'b0}}};
  assign w_br = w_sb << 2;

  always_comb begin
    w_ext = w_za;
    case (mode)
      M_SA:    w_ext = w_sa;
      M_ZB:    w_ext = w_zb;
      M_SB:    w_ext = w_sb;
      M_UP:    w_ext = w_up;
      M_BR:    w_ext = w_br;
      default: w_ext = w_za;
    endcase
  end

  assign w_res = w_use_pfx ? {r_pfx, imm_a} : w_ext;

  always_comb begin
    w_state_nxt = r_state;
    if (flush)
      w_state_nxt = S_IDLE;
    else if (w_accept)
      w_state_nxt = w_is_pfx ? S_PFX : S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_pfx <= '0;
    else if (flush)
      r_pfx <= '0;
    else if (w_accept && w_is_pfx)
      r_pfx <= imm_a[PFX_W-1:0];
  end

  // Output stage: flush wins, then a new non-prefix result, then consumer drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_imm       <= '0;
      r_pfx_used  <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
      r_pfx_used  <= 1'b0;
    end else if (w_accept && !w_is_pfx) begin
      r_out_valid <= 1'b1;
      r_imm       <= w_res;
      r_pfx_used  <= w_use_pfx;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_err <= 1'b0;
    else        r_err <= !flush && w_accept && w_viol;
  end

  assign out_valid = r_out_valid;
  assign imm_out   = r_imm;
  assign pfx_used  = r_pfx_used;
  assign err       = r_err;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Scoreboard bench for imm_ext_pipe: the driver pushes expected results on
// accept, a negedge monitor pops and compares them and checks err timing.
module tb_imm_ext_pipe;

  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic [2:0]  mode = '0;
  logic [15:0] imm_a = '0;
  logic [23:0] imm_b = '0;
  logic        in_ready, out_valid, pfx_used, err;
  logic [31:0] imm_out;

  imm_ext_pipe #(.DATA_W(32), .IMM_A_W(16), .IMM_B_W(24), .PFX_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .imm_a(imm_a), .imm_b(imm_b), .out_valid(out_valid),
    .out_ready(out_ready), .imm_out(imm_out), .pfx_used(pfx_used), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed { logic [31:0] imm; logic pu; } exp_t;
  exp_t        sb[$];
  int          n_chk = 0, n_fail = 0;
  int          err_due = -1;
  bit          m_pfx = 1'b0;
  logic [15:0] m_pfx_val = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] m, input logic [15:0] a,
                                        input logic [23:0] b);
    logic signed [31:0] sa, sbx;
    sa  = $signed(a);
    sbx = $signed(b);
    case (m)
      3'd1:    return sa;
      3'd2:    return {8'h00, b};
      3'd3:    return sbx;
      3'd4:    return {a, 16'h0000};
      3'd5:    return sbx * 4;
      default: return {16'h0000, a};
    endcase
  endfunction

  // Present one request from posedge+1 until accepted; record expectations.
  task automatic send(input logic [2:0] m, input logic [15:0] a, input logic [23:0] b);
    bit rdy, done, viol;
    done = 1'b0;
    mode = m; imm_a = a; imm_b = b; in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk); rdy = in_ready;
      @(posedge clk); #1;
      if (rdy) begin
        done = 1'b1;
        viol = (m == 3'd7) || (m_pfx && m >= 3'd2);
        if (viol) err_due = cyc;
        if (m == 3'd6) begin
          m_pfx = 1'b1; m_pfx_val = a;
        end else begin
          if (m_pfx && m <= 3'd1) sb.push_back(exp_t'{imm: {m_pfx_val, a}, pu: 1'b1});
          else                    sb.push_back(exp_t'{imm: model(m, a, b), pu: 1'b0});
          m_pfx = 1'b0;
        end
      end
    end
    if (!done) chk("send_timeout", {63'd0, done}, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      chk("err", err, (cyc == err_due));
      if (out_valid) begin
        if (sb.size() == 0) chk("out_valid_unexpected", out_valid, 1'b0);
        else begin
          chk("imm_out", imm_out, sb[0].imm);
          chk("pfx_used", pfx_used, sb[0].pu);
          if (out_ready) void'(sb.pop_front());
        end
      end
    end
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_imm_out", imm_out, 32'h0);
    chk("rst_pfx_used", pfx_used, 1'b0);
    chk("rst_err", err, 1'b0);
    sb.delete(); err_due = -1; m_pfx = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    chk("post_rst_in_ready", in_ready, 1'b1);
  endtask

  initial begin
    fork monitor(); join_none
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_imm_out", imm_out, 32'h0);
    chk("reset_pfx_used", pfx_used, 1'b0);
    chk("reset_err", err, 1'b0);
    rst_n = 1'b1;
    chk("reset_in_ready", in_ready, 1'b1);

    // mode sweep, including reserved mode 7
    out_ready = 1'b1;
    for (int m = 0; m < 6; m++) send(3'(m), 16'h8001, 24'h800004);
    send(3'd7, 16'h8001, 24'h800004);

    // prefix build
    send(3'd6, 16'hDEAD, 24'h0);
    send(3'd0, 16'hBEEF, 24'h0);

    // prefix violations: discard on mode3, overwrite on mode6, then clean mode0
    send(3'd6, 16'h1234, 24'h0);
    send(3'd3, 16'h0000, 24'h000010);
    send(3'd0, 16'h0007, 24'h0);
    send(3'd6, 16'h1111, 24'h0);
    send(3'd6, 16'h2222, 24'h0);
    send(3'd1, 16'h8000, 24'h0);

    // backpressure: three mode1 requests, consumer stalled 4 cycles
    out_ready = 1'b0;
    fork
      begin
        repeat (2) @(negedge clk);
        chk("bp_in_ready_low", in_ready, 1'b0);
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b1;
      end
      begin
        send(3'd1, 16'h0001, 24'h0);
        send(3'd1, 16'h0002, 24'h0);
        send(3'd1, 16'h0003, 24'h0);
      end
    join

    // flush after a prefix, with a request present in the flush cycle
    send(3'd6, 16'hAAAA, 24'h0);
    flush = 1'b1; in_valid = 1'b1; mode = 3'd0; imm_a = 16'h0077;
    #1 chk("flush_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; m_pfx = 1'b0;
    chk("flush_out_valid", out_valid, 1'b0);
    send(3'd0, 16'h0005, 24'h0);

    // async reset with a pending result and an err pulse in flight
    out_ready = 1'b1;
    send(3'd6, 16'h3333, 24'h0);
    out_ready = 1'b0;
    send(3'd4, 16'h4444, 24'h0);
    chk("pre_rst_out_valid", out_valid, 1'b1);
    async_reset();
    out_ready = 1'b1;
    send(3'd2, 16'h0, 24'h00ABCD);

    // async reset while a prefix is pending: prefix must be gone afterwards
    send(3'd6, 16'h5555, 24'h0);
    async_reset();
    send(3'd0, 16'h0042, 24'h0);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
